pc_sequencer: RTL

//  Owns the fetch PC register and sequences its updates for the 5-stage pipeline.

---
 rtl/pc_sequencer_if.sv | 25 ++
 rtl/pc_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-sequencer bus: EX redirect, hazard stall and imem handshake in,
// fetch PC and pipeline control strobes out.
interface pc_sequencer_if;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        ld_use_stall;
  logic        imem_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic        pc_write;
  logic        if_id_flush;
  logic        id_ex_flush;

  // Pipeline side: drives EX/hazard/imem inputs, observes fetch controls
  modport master (
    output ex_redirect, ex_target, ld_use_stall, imem_ready,
    input  pc, imem_req, pc_write, if_id_flush, id_ex_flush
  );

  // Sequencer side
  modport slave (
    input  ex_redirect, ex_target, ld_use_stall, imem_ready,
    output pc, imem_req, pc_write, if_id_flush, id_ex_flush
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and arbitrates redirect > load-use stall >
// imem wait. Misaligned redirect targets trap into HALT until reset.
// Optional feature macro: PCSEQ_PERF_EN adds saturating redirect/stall counters.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PCSEQ_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  pc_sequencer_if.slave    bus,
  output logic [1:0]       seq_state_o,
  output logic             misalign_err_o
`ifdef PCSEQ_PERF_EN
  , output logic [CNT_W-1:0] redirect_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        err_q, err_d;

  // Per-cycle decisions, shared by the datapath and counters
  logic active;      // FETCH or WAIT
  logic redir_ok;    // aligned redirect accepted
  logic redir_bad;   // misaligned redirect -> trap
  logic advance;     // sequential pc+4
  logic held;        // active cycle, no redirect, pc not written

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_BOOT;
    else         state_q <= state_d;
  end

  // Next-state logic: redirect beats stall beats memory wait
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH, S_WAIT: begin
        if (bus.ex_redirect)
          state_d = (bus.ex_target[1:0] != 2'b00) ? S_HALT : S_FETCH;
        else if (bus.ld_use_stall)
          state_d = state_q;
        else if (bus.imem_ready)
          state_d = S_FETCH;
        else
          state_d = S_WAIT;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_BOOT;
    endcase
  end

  // Output logic: Mealy strobes, all zero outside FETCH/WAIT
  always_comb begin
    active    = (state_q == S_FETCH) || (state_q == S_WAIT);
    redir_ok  = 1'b0;
    redir_bad = 1'b0;
    advance   = 1'b0;
    held      = 1'b0;
    if (active) begin
      if (bus.ex_redirect) begin
        if (bus.ex_target[1:0] == 2'b00) redir_ok  = 1'b1;
        else                             redir_bad = 1'b1;
      end else if (!bus.ld_use_stall && bus.imem_ready) begin
        advance = 1'b1;
      end else begin
        held = 1'b1;
      end
    end
    bus.imem_req    = active;
    bus.pc_write    = redir_ok | advance;
    bus.if_id_flush = active & bus.ex_redirect;
    bus.id_ex_flush = active & bus.ex_redirect;
  end

  // PC / sticky-error next values; low pc bits are forced to zero
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q | redir_bad;
    if (redir_ok)     pc_d = {bus.ex_target[31:2], 2'b00};
    else if (advance) pc_d = pc_q + 32'd4;
  end

  // PC and misalign flag registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q  <= {RESET_PC[31:2], 2'b00};
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc         = pc_q;
  assign seq_state_o    = state_q;
  assign misalign_err_o = err_q;

`ifdef PCSEQ_PERF_EN
  logic [CNT_W-1:0] rcnt_q, rcnt_d, scnt_q, scnt_d;

  // Saturating counter next values
  always_comb begin
    rcnt_d = rcnt_q;
    scnt_d = scnt_q;
    if (redir_ok && (rcnt_q != {CNT_W{1'b1}})) rcnt_d = rcnt_q + 1'b1;
    if (held     && (scnt_q != {CNT_W{1'b1}})) scnt_d = scnt_q + 1'b1;
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      rcnt_q <= rcnt_d;
      scnt_q <= scnt_d;
    end
  end

  assign redirect_cnt_o = rcnt_q;
  assign stall_cnt_o    = scnt_q;
`endif

endmodule
